// File: rtl/program_counter.sv
// RV32I program counter: holds the fetch address and advances once per clock
// from hold, sequential +4, register-indirect load, or PC-relative branch.
module program_counter (
    input  logic        clk,
    input  logic        clr,
    input  logic        load,
    input  logic        inc,
    input  logic        ALU_out,
    input  logic        Disable,
    input  logic [31:0] data,
    input  logic [31:0] imm_val,
    output logic [31:0] pc_val
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_branch_off;
    logic [31:0] w_load_target;
    logic [31:0] w_branch_target;
    logic [31:0] w_seq_target;

    // Word offset to byte offset; bits 31:30 of the immediate fall off the top.
    assign w_branch_off    = {imm_val[29:0], 2'b00};
    assign w_load_target   = data + 32'd4;
    assign w_branch_target = r_pc + w_branch_off;
    assign w_seq_target    = r_pc + 32'd4;

    always_comb begin
        w_pc_next = r_pc;
        if (Disable) begin
            w_pc_next = r_pc;
        end else if (load) begin
            w_pc_next = w_load_target;
        end else if (ALU_out) begin
            w_pc_next = w_branch_target;
        end else if (inc) begin
            w_pc_next = w_seq_target;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_pc <= 32'd0;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign pc_val = r_pc;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed vector table, hand-written
// reset sequences, and randomized stimulus against a word-offset reference model.
module tb_program_counter;

    logic        clk;
    logic        clr;
    logic        load;
    logic        inc;
    logic        ALU_out;
    logic        Disable;
    logic [31:0] data;
    logic [31:0] imm_val;
    logic [31:0] pc_val;

    int n_total;
    int n_pass;

    typedef struct {
        logic        dis;
        logic        ld;
        logic        alu;
        logic        in;
        logic [31:0] d;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    program_counter dut (
        .clk     (clk),
        .clr     (clr),
        .load    (load),
        .inc     (inc),
        .ALU_out (ALU_out),
        .Disable (Disable),
        .data    (data),
        .imm_val (imm_val),
        .pc_val  (pc_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: next PC from the priority rules using signed word offsets mod 2^32.
    function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic dis,
                                             input logic ld, input logic alu, input logic in,
                                             input logic [31:0] d, input logic [31:0] imm);
        longint sum;
        if (dis) return pc;
        if (ld) begin
            sum = longint'(d) + 4;
            return sum[31:0];
        end
        if (alu) begin
            sum = longint'(pc) + longint'($signed(imm)) * 4;
            return sum[31:0];
        end
        if (in) begin
            sum = longint'(pc) + 4;
            return sum[31:0];
        end
        return pc;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
            $display("ok   %s: pc_val=%h", name, act);
        end else begin
            $display("FAIL %s: pc_val=%h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic dis, input logic ld, input logic alu, input logic in,
                         input logic [31:0] d, input logic [31:0] imm);
        Disable = dis;
        load    = ld;
        ALU_out = alu;
        inc     = in;
        data    = d;
        imm_val = imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic dis, input logic ld, input logic alu, input logic in,
                       input logic [31:0] d, input logic [31:0] imm, input logic [31:0] exp);
        vec_t v;
        v.dis = dis; v.ld = ld; v.alu = alu; v.in = in;
        v.d = d; v.imm = imm; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] model_pc;
        n_total = 0;
        n_pass  = 0;

        //   dis ld  alu in   data          imm           expected
        add(0, 0, 0, 1, 32'd0,         32'd0,         32'd4);
        add(0, 0, 0, 1, 32'd0,         32'd0,         32'd8);
        add(0, 1, 0, 0, 32'd20,        32'd0,         32'd24);
        add(1, 1, 0, 0, 32'd0,         32'd0,         32'd24);
        add(1, 1, 0, 0, 32'd0,         32'd0,         32'd24);
        add(1, 1, 0, 0, 32'd0,         32'd0,         32'd24);
        add(1, 1, 0, 0, 32'd0,         32'd0,         32'd24);
        add(0, 1, 0, 0, 32'd12,        32'd0,         32'd16);
        add(0, 0, 1, 0, 32'd0,         32'hFFFF_FFFE, 32'd8);
        add(0, 1, 0, 0, 32'd12,        32'd0,         32'd16);
        add(0, 0, 1, 1, 32'd0,         32'hFFFF_FFFE, 32'd8);
        add(0, 1, 1, 1, 32'd100,       32'd5,         32'd104);
        add(0, 0, 0, 0, 32'd7,         32'd9,         32'd104);
        add(0, 0, 0, 0, 32'd7,         32'd9,         32'd104);
        add(0, 0, 0, 0, 32'd7,         32'd9,         32'd104);
        add(0, 1, 0, 0, 32'hFFFF_FFF8, 32'd0,         32'hFFFF_FFFC);
        add(0, 0, 0, 1, 32'd0,         32'd0,         32'h0000_0000);
        add(0, 0, 1, 0, 32'd0,         32'd2,         32'd8);
        add(0, 0, 1, 0, 32'd0,         32'hC000_0001, 32'd12);
        add(0, 1, 0, 0, 32'd3,         32'd0,         32'd7);
        add(1, 0, 1, 1, 32'd0,         32'd50,        32'd7);
        add(0, 0, 1, 0, 32'd0,         32'h3FFF_FFFF, 32'd3);

        clr = 1'b0;
        drive(0, 0, 0, 0, 32'd0, 32'd0);
        #12;
        check("reset", pc_val, 32'd0);
        tick();
        check("reset_held_over_edge", pc_val, 32'd0);
        clr = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].dis, vecs[i].ld, vecs[i].alu, vecs[i].in, vecs[i].d, vecs[i].imm);
            tick();
            check($sformatf("vec%0d", i), pc_val, vecs[i].exp);
        end

        // Async clear mid-cycle: no clock edge between assertion and check.
        drive(0, 0, 0, 1, 32'd0, 32'd0);
        tick();
        check("inc_before_clr", pc_val, 32'd7);
        clr = 1'b0;
        #2;
        check("async_clr_no_edge", pc_val, 32'd0);
        drive(0, 1, 1, 1, 32'd400, 32'd9);
        tick();
        check("clr_low_ignores_load", pc_val, 32'd0);
        tick();
        check("clr_low_second_edge", pc_val, 32'd0);

        // Release between edges; first edge with clr high applies the branch.
        drive(0, 0, 1, 0, 32'd0, 32'd2);
        #2;
        clr = 1'b1;
        tick();
        check("branch_after_release", pc_val, 32'd8);

        // Clear asserted with a load pending discards the load.
        drive(0, 1, 0, 0, 32'd40, 32'd0);
        #1;
        clr = 1'b0;
        tick();
        check("clr_discards_pending", pc_val, 32'd0);
        drive(0, 0, 0, 1, 32'd0, 32'd0);
        clr = 1'b1;
        tick();
        check("inc_after_release_1", pc_val, 32'd4);
        tick();
        check("inc_after_release_2", pc_val, 32'd8);

        // Randomized traffic against the reference model.
        model_pc = 32'd8;
        for (int n = 0; n < 400; n++) begin
            logic dis, ld, alu, in;
            logic [31:0] d, imm;
            dis = ($urandom_range(0, 7) == 0);
            ld  = ($urandom_range(0, 4) == 0);
            alu = ($urandom_range(0, 2) == 0);
            in  = ($urandom_range(0, 1) == 0);
            d   = $urandom;
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = $urandom_range(0, 64);
                2: imm = -$urandom_range(0, 64);
                default: imm = {2'($urandom_range(0, 3)), 30'($urandom_range(0, 15))};
            endcase
            drive(dis, ld, alu, in, d, imm);
            if ($urandom_range(0, 39) == 0) begin
                clr = 1'b0;
                #1;
                check($sformatf("rnd%0d_async", n), pc_val, 32'd0);
                model_pc = 32'd0;
                tick();
                check($sformatf("rnd%0d_held", n), pc_val, 32'd0);
                clr = 1'b1;
            end else begin
                model_pc = ref_next(model_pc, dis, ld, alu, in, d, imm);
                tick();
                check($sformatf("rnd%0d", n), pc_val, model_pc);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
